control_cafetera: RTL
=====================

CONTROL_CAFETERA -- requirements
Module: control_cafetera

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL update on the rising edge of clk_100MHz.
REQ-002 clk_100MHz  in  1  system clock, 100 MHz.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 btn_start  in  1  start request, synchronous to clk_100MHz; only its 0->1 edge is used.
REQ-005 btn_cancel  in  1  cancel/acknowledge, level-sensitive.
REQ-006 coffee_sel  in  2  drink select: 00 espresso, 01 americano, 10 latte, 11 invalid.
REQ-007 cup_present  in  1  cup sensor, 1 = cup in place.
REQ-008 water_ok  in  1  tank sensor, 1 = water available.
REQ-009 texpired  in  1  from downstream timer, 1 = programmed interval elapsed.
REQ-010 start_timer  out  1  one-cycle pulse that (re)starts the timer.
REQ-011 value  out  1  timer interval select: 0 short, 1 long.
REQ-012 heater_on, pump_on, milk_on  out  1 each  actuator enables.
REQ-013 ready  out  1  machine idle and accepting orders.
REQ-014 fault  out  1  machine in FAULT state.
REQ-015 state  out  3  current state code.
REQ-016 cups_served  out  8  completed drinks.

Function
REQ-017 States and codes SHALL be IDLE=0, HEAT=1, BREW=2, MILK=3, DONE=4, FAULT=5; codes 6-7 SHALL go to IDLE on the next clock.
REQ-018 IDLE->HEAT SHALL occur on a btn_start rising edge (btn_start=1, previous-cycle btn_start=0) with cup_present=1, water_ok=1 and coffee_sel!=11; otherwise stay in IDLE.
REQ-019 coffee_sel SHALL be latched on the IDLE->HEAT transition; later changes SHALL have no effect until the next order.
REQ-020 Timed states are HEAT, BREW and MILK; start_timer SHALL be 1 during the first cycle of each timed state only, including when a timed state is entered from another timed state.
REQ-021 value SHALL be stable for the whole of a timed state: HEAT=1; BREW=0 for espresso and latte, 1 for americano; MILK=0.
REQ-022 In timed states texpired SHALL be ignored during the start_timer cycle and sampled from the next cycle on.
REQ-023 On texpired=1: HEAT->BREW; BREW->MILK if latte, else BREW->DONE; MILK->DONE.
REQ-024 Actuators SHALL be combinational on the state: heater_on=1 in HEAT and BREW; pump_on=1 in BREW only; milk_on=1 in MILK only; all 0 elsewhere.
REQ-025 In any timed state, btn_cancel=1, water_ok=0 or cup_present=0 SHALL go to FAULT; this condition SHALL take priority over texpired in the same cycle.
REQ-026 FAULT->IDLE SHALL require btn_cancel=1 with water_ok=1 and cup_present=1 in the same cycle.
REQ-027 On entry to DONE, cups_served SHALL increment by 1 and saturate at 255.
REQ-028 DONE->IDLE SHALL occur when cup_present=0.
REQ-029 Outputs: ready=1 only in IDLE; fault=1 only in FAULT; start_timer=0 in non-timed states; value=0 in non-timed states.

Reset
REQ-030 While rst_n=0, and without waiting for a clock edge, the block SHALL force: state=IDLE; cups_served=0; latched selection=00; btn_start history=1, so a button held through reset does not start an order; start_timer, value, heater_on, pump_on, milk_on and fault=0; ready=1.
REQ-031 Reset asserted mid-brew SHALL turn off all actuators immediately and discard the order.

Verification
REQ-032 Espresso: reset, cup/water=1, sel=00, btn_start pulse -> HEAT with start_timer pulse, value=1; texpired -> BREW with start_timer pulse, value=0, pump_on=1; texpired -> DONE, cups_served=1; cup_present=0 -> IDLE, ready=1.
REQ-033 Latte: sel=10 -> HEAT->BREW(value 0)->MILK(value 0, milk_on=1)->DONE, with exactly three start_timer pulses; change sel mid-brew -> no effect.
REQ-034 Fault priority: in BREW, drive water_ok=0 and texpired=1 in the same cycle -> FAULT, all actuators 0, cups_served unchanged; btn_cancel=1 with sensors OK -> IDLE.
REQ-035 Rejects: sel=11, cup_present=0, or btn_start held high through reset release -> remains IDLE; texpired=1 held during a start_timer cycle -> no transition that cycle.
REQ-036 Saturation/reset: complete 256 drinks -> cups_served=255; assert rst_n=0 mid-HEAT -> heater_on=0 immediately and cups_served=0.

Source files
------------

// File: rtl/control_cafetera.sv
// Purpose: sequencing FSM for a coffee machine (heat, brew, optional milk) with a sensor fault path and a saturating drink counter.
// Latency: state changes one clk_100MHz edge after the deciding inputs; actuators, ready, fault and value decode the state with no added delay.
// Backpressure: none; every input is sampled every cycle and the downstream timer is restarted by a one-cycle start_timer pulse.
module control_cafetera (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_cancel,
  input  logic [1:0] coffee_sel,
  input  logic       cup_present,
  input  logic       water_ok,
  input  logic       texpired,
  output logic       start_timer,
  output logic       value,
  output logic       heater_on,
  output logic       pump_on,
  output logic       milk_on,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] cups_served
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HEAT  = 3'd1;
  localparam logic [2:0] ST_BREW  = 3'd2;
  localparam logic [2:0] ST_MILK  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  localparam logic [1:0] SEL_ESPRESSO  = 2'b00;
  localparam logic [1:0] SEL_AMERICANO = 2'b01;
  localparam logic [1:0] SEL_LATTE     = 2'b10;
  localparam logic [1:0] SEL_INVALID   = 2'b11;

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic       r_btn_prev;     // previous-cycle btn_start, for edge detection
  logic [1:0] r_sel;          // drink latched when the order is accepted
  logic       r_start;        // high during the first cycle of a timed state
  logic [7:0] r_cups;

  logic       w_start_edge;
  logic       w_order_ok;
  logic       w_sensor_fault;
  logic       w_expired;
  logic       w_is_timed;
  logic       w_next_timed;
  logic       w_enter_done;

  // Order acceptance and abort qualifiers.
  always_comb begin
    w_start_edge   = btn_start & ~r_btn_prev;
    w_order_ok     = w_start_edge & cup_present & water_ok & (coffee_sel != SEL_INVALID);
    w_sensor_fault = btn_cancel | ~water_ok | ~cup_present;
    // The timer has just been restarted in the first cycle, so its expiry flag is stale there.
    w_expired      = texpired & ~r_start;
  end

  // Next-state decision; faults win over timer expiry in timed states.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_order_ok) w_next_state = ST_HEAT;
      end
      ST_HEAT: begin
        if (w_sensor_fault) w_next_state = ST_FAULT;
        else if (w_expired) w_next_state = ST_BREW;
      end
      ST_BREW: begin
        if (w_sensor_fault) w_next_state = ST_FAULT;
        else if (w_expired) w_next_state = (r_sel == SEL_LATTE) ? ST_MILK : ST_DONE;
      end
      ST_MILK: begin
        if (w_sensor_fault) w_next_state = ST_FAULT;
        else if (w_expired) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        if (!cup_present) w_next_state = ST_IDLE;
      end
      ST_FAULT: begin
        if (btn_cancel && water_ok && cup_present) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;   // unused codes 6 and 7 recover to IDLE
    endcase
  end

  // Classify current and next state for timer restart and counter update.
  always_comb begin
    w_is_timed   = (r_state == ST_HEAT) || (r_state == ST_BREW) || (r_state == ST_MILK);
    w_next_timed = (w_next_state == ST_HEAT) || (w_next_state == ST_BREW) ||
                   (w_next_state == ST_MILK);
    w_enter_done = (w_next_state == ST_DONE) && (r_state != ST_DONE);
  end

  // State register.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Timer restart flag: set on every entry into a timed state, including timed->timed.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) r_start <= 1'b0;
    else        r_start <= w_next_timed && (w_next_state != r_state);
  end

  // Button history resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) r_btn_prev <= 1'b1;
    else        r_btn_prev <= btn_start;
  end

  // Drink selection is captured only when an order is accepted.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n)                                               r_sel <= SEL_ESPRESSO;
    else if (r_state == ST_IDLE && w_next_state == ST_HEAT) r_sel <= coffee_sel;
  end

  // Completed-drink counter, saturating at 255.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n)                             r_cups <= 8'd0;
    else if (w_enter_done && r_cups != 8'hFF) r_cups <= r_cups + 8'd1;
  end

  // Output decode straight from the state so reset clears actuators immediately.
  always_comb begin
    heater_on   = 1'b0;
    pump_on     = 1'b0;
    milk_on     = 1'b0;
    value       = 1'b0;
    start_timer = r_start & w_is_timed;
    ready       = (r_state == ST_IDLE);
    fault       = (r_state == ST_FAULT);
    state       = r_state;
    cups_served = r_cups;
    case (r_state)
      ST_HEAT: begin
        heater_on = 1'b1;
        value     = 1'b1;
      end
      ST_BREW: begin
        heater_on = 1'b1;
        pump_on   = 1'b1;
        value     = (r_sel == SEL_AMERICANO);
      end
      ST_MILK: begin
        milk_on   = 1'b1;
      end
      default: begin
        value     = 1'b0;
      end
    endcase
  end

endmodule
